// File: rtl/rv32i_if_stage_if.sv
// Instruction-memory request/grant/response bus between the fetch stage and imem.
interface rv32i_if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/rv32i_if_stage.sv
// rv32i instruction-fetch stage: owns the fetch PC, keeps one imem request in flight
// and parks a response that decode cannot take yet in a one-entry hold buffer.
module rv32i_if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stall_if_i,
    input  logic                    flush_if_i,
    input  logic                    pc_sel_i,
    input  logic [31:0]             exif_pc_bj_i,
    rv32i_if_stage_if.master        imem,
    output logic [31:0]             ifid_pc_o,
    output logic [31:0]             ifid_instr_o,
    output logic                    ifid_valid_o,
    output logic                    if_busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, fetch_pc_q, target;
    logic [31:0] hb_pc_q, hb_instr_q;
    logic        hb_valid_q;
    logic        rsp_live, hb_fill, mem_load, hb_drain, grant;

    always_comb begin
        target   = pc_sel_i ? (exif_pc_bj_i & 32'hFFFF_FFFC) : pc_q;
        // A live response is one for the current stream that has not been redirected away.
        rsp_live = (state_q == WAIT) && imem.rvalid && !pc_sel_i;
        hb_fill  = rsp_live && (stall_if_i || flush_if_i);
        mem_load = rsp_live && !stall_if_i && !flush_if_i;
        hb_drain = hb_valid_q && !stall_if_i && !flush_if_i && !pc_sel_i;
        imem.req  = !rst_i && !hb_valid_q && !hb_fill &&
                    ((state_q == IDLE) || imem.rvalid);
        imem.addr = target;
        grant     = imem.req && imem.gnt;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = WAIT;
            WAIT: begin
                if (imem.rvalid)   state_d = grant ? WAIT : IDLE;
                else if (pc_sel_i) state_d = DISCARD;
            end
            DISCARD: if (imem.rvalid) state_d = grant ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign if_busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
            fetch_pc_q   <= 32'h0;
            hb_valid_q   <= 1'b0;
            hb_pc_q      <= 32'h0;
            hb_instr_q   <= NOP_INSTR;
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_INSTR;
            ifid_pc_o    <= 32'h0;
        end else begin
            if (grant) begin
                fetch_pc_q <= target;
                pc_q       <= target + 32'd4;
            end else if (pc_sel_i) begin
                pc_q <= target;
            end

            if (pc_sel_i || hb_drain) begin
                hb_valid_q <= 1'b0;
            end else if (hb_fill) begin
                hb_valid_q <= 1'b1;
                hb_pc_q    <= fetch_pc_q;
                hb_instr_q <= imem.rdata;
            end

            // Bubbles keep the old PC; only valid and the instruction word change.
            if (pc_sel_i || flush_if_i) begin
                ifid_valid_o <= 1'b0;
                ifid_instr_o <= NOP_INSTR;
            end else if (!stall_if_i) begin
                if (hb_valid_q) begin
                    ifid_valid_o <= 1'b1;
                    ifid_pc_o    <= hb_pc_q;
                    ifid_instr_o <= hb_instr_q;
                end else if (mem_load) begin
                    ifid_valid_o <= 1'b1;
                    ifid_pc_o    <= fetch_pc_q;
                    ifid_instr_o <= imem.rdata;
                end else begin
                    ifid_valid_o <= 1'b0;
                    ifid_instr_o <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_if_stage.sv
// Bench for rv32i_if_stage: latency-configurable memory responder plus a program-order
// scoreboard (next expected PC / next expected fetch address).
module tb_rv32i_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, pc_sel = 1'b0;
    logic [31:0] bj = 32'h0;
    logic [31:0] ifid_pc, ifid_instr;
    logic        ifid_valid, if_busy;

    int n_chk = 0, n_fail = 0;
    int lat = 0, gnt_pct = 100, mem_cnt = 0, proto_err = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_a = 32'h0;
    logic [31:0] exp_pc = 32'h0, exp_fetch = 32'h0;

    rv32i_if_stage_if imem();

    rv32i_if_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .rst_i(rst), .stall_if_i(stall), .flush_if_i(flush),
        .pc_sel_i(pc_sel), .exif_pc_bj_i(bj), .imem(imem.master),
        .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr),
        .ifid_valid_o(ifid_valid), .if_busy_o(if_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Memory: records a grant at the edge, answers lat cycles later, one request at a time.
    initial begin
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (imem.rvalid) mem_busy = 1'b0;
            if (imem.req && imem.gnt) begin
                if (mem_busy) proto_err++;
                mem_busy = 1'b1; mem_a = imem.addr; mem_cnt = lat;
            end else if (mem_busy && mem_cnt > 0) begin
                mem_cnt--;
            end
            #1;
            imem.gnt    = ($urandom_range(99) < gnt_pct);
            imem.rvalid = mem_busy && (mem_cnt == 0);
            imem.rdata  = imem.rvalid ? memword(mem_a) : $urandom();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic do_reset(input int l, input int gp);
        lat = l; gnt_pct = gp; rst = 1'b1;
        stall = 1'b0; flush = 1'b0; pc_sel = 1'b0; bj = 32'h0;
        repeat (6) cyc();
        rst = 1'b0; exp_pc = 32'h0; exp_fetch = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; lat = 0; gnt_pct = 100;
        repeat (3) cyc();
        n_chk++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
        n_chk++; if (ifid_instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", ifid_instr, NOP); end
        n_chk++; if (ifid_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", ifid_pc); end
        n_chk++; if (if_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if_busy); end
        #1;
        n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem.req); end
    endtask

    task automatic test_zero_wait();
        do_reset(0, 100);
        #1;
        n_chk++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin n_fail++; $display("FAIL zw_first_req: req=%b addr=%h want 1/0", imem.req, imem.addr); end
        cyc();
        n_chk++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL zw_cycle1: valid=%b want 0", ifid_valid); end
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_chk++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 32'(4 * i) || ifid_instr !== memword(32'(4 * i))) begin
                n_fail++; $display("FAIL zw_stream[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h", i, ifid_valid, ifid_pc, ifid_instr, 32'(4 * i), memword(32'(4 * i)));
            end
        end
    endtask

    task automatic test_latency();
        int got = 0; logic pv = 1'b0;
        do_reset(3, 100);
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (ifid_valid) begin
                n_chk++; if (ifid_pc !== exp_pc || ifid_instr !== memword(exp_pc)) begin n_fail++; $display("FAIL lat_seq: pc=%h instr=%h want %h/%h", ifid_pc, ifid_instr, exp_pc, memword(exp_pc)); end
                n_chk++; if (pv) begin n_fail++; $display("FAIL lat_pulse: valid high two cycles in a row at pc=%h, want single pulse", ifid_pc); end
                exp_pc += 32'd4; got++;
            end
            pv = ifid_valid;
            n_chk++; if (if_busy !== mem_busy) begin n_fail++; $display("FAIL lat_busy: got %b want %b", if_busy, mem_busy); end
            #1;
            if (mem_busy && !imem.rvalid) begin
                n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL lat_req_wait: got %b want 0", imem.req); end
            end
        end
        n_chk++; if (got < 12) begin n_fail++; $display("FAIL lat_count: got %0d want >=12", got); end
    endtask

    task automatic test_stall();
        int got = 0; logic [31:0] hpc, hin;
        do_reset(0, 100);
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (ifid_valid) begin
                n_chk++; if (ifid_pc !== exp_pc || ifid_instr !== memword(exp_pc)) begin n_fail++; $display("FAIL st_pre: pc=%h want %h", ifid_pc, exp_pc); end
                exp_pc += 32'd4;
            end
        end
        hpc = ifid_pc; hin = ifid_instr;
        stall = 1'b1;
        #1;
        n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL st_req_fill: got %b want 0", imem.req); end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_chk++; if (ifid_valid !== 1'b1 || ifid_pc !== hpc || ifid_instr !== hin) begin n_fail++; $display("FAIL st_frozen[%0d]: pc=%h instr=%h want %h/%h", k, ifid_pc, ifid_instr, hpc, hin); end
            if (k == 4) stall = 1'b0;
            #1;
            n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL st_req[%0d]: got %b want 0", k, imem.req); end
        end
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ifid_valid) begin
                n_chk++; if (ifid_pc !== exp_pc || ifid_instr !== memword(exp_pc)) begin n_fail++; $display("FAIL st_post: pc=%h instr=%h want %h/%h", ifid_pc, ifid_instr, exp_pc, memword(exp_pc)); end
                exp_pc += 32'd4; got++;
            end
        end
        n_chk++; if (got < 8) begin n_fail++; $display("FAIL st_count: got %0d want >=8", got); end
    endtask

    task automatic test_redirect();
        bit found = 0, seen_req = 0; int got = 0;
        do_reset(3, 100);
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (ifid_valid) begin
                n_chk++; if (ifid_pc !== exp_pc) begin n_fail++; $display("FAIL rd_pre: pc=%h want %h", ifid_pc, exp_pc); end
                exp_pc += 32'd4;
            end
            #1;
            if (imem.req && imem.gnt && imem.addr == 32'h10) found = 1;
        end
        n_chk++; if (!found) begin n_fail++; $display("FAIL rd_find: request to 00000010 not seen, want seen"); end
        cyc();
        if (ifid_valid) begin
            n_chk++; if (ifid_pc !== exp_pc) begin n_fail++; $display("FAIL rd_pre2: pc=%h want %h", ifid_pc, exp_pc); end
        end
        pc_sel = 1'b1; bj = 32'h0000_0102; exp_pc = 32'h100;
        #1;
        n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL rd_req_wait: got %b want 0", imem.req); end
        cyc();
        pc_sel = 1'b0;
        n_chk++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_fail++; $display("FAIL rd_bubble: valid=%b instr=%h want 0/%h", ifid_valid, ifid_instr, NOP); end
        for (int i = 0; i < 30; i++) begin
            if (ifid_valid) begin
                n_chk++; if (ifid_pc !== exp_pc || ifid_instr !== memword(exp_pc)) begin n_fail++; $display("FAIL rd_post: pc=%h instr=%h want %h/%h", ifid_pc, ifid_instr, exp_pc, memword(exp_pc)); end
                exp_pc += 32'd4; got++;
            end
            #1;
            if (imem.req && imem.gnt && !seen_req) begin
                seen_req = 1;
                n_chk++; if (imem.addr !== 32'h100) begin n_fail++; $display("FAIL rd_addr: got %h want 00000100", imem.addr); end
            end
            cyc();
        end
        n_chk++; if (got < 3) begin n_fail++; $display("FAIL rd_count: got %0d want >=3", got); end
    endtask

    task automatic test_flush();
        int got = 0; logic [31:0] ppc;
        do_reset(0, 100);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (ifid_valid) begin
                n_chk++; if (ifid_pc !== exp_pc) begin n_fail++; $display("FAIL fl_pre: pc=%h want %h", ifid_pc, exp_pc); end
                exp_pc += 32'd4;
            end
        end
        ppc = ifid_pc; flush = 1'b1;
        cyc();
        flush = 1'b0;
        n_chk++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== ppc) begin n_fail++; $display("FAIL fl_bubble: valid=%b instr=%h pc=%h want 0/%h/%h", ifid_valid, ifid_instr, ifid_pc, NOP, ppc); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (ifid_valid) begin
                n_chk++; if (ifid_pc !== exp_pc || ifid_instr !== memword(exp_pc)) begin n_fail++; $display("FAIL fl_post: pc=%h instr=%h want %h/%h", ifid_pc, ifid_instr, exp_pc, memword(exp_pc)); end
                exp_pc += 32'd4; got++;
            end
        end
        n_chk++; if (got < 5) begin n_fail++; $display("FAIL fl_count: got %0d want >=5", got); end
    endtask

    task automatic test_reset_midway();
        bit seen = 0, hit = 0; int got = 0;
        do_reset(3, 100);
        for (int i = 0; i < 40 && !hit; i++) begin
            cyc();
            if (seen && if_busy && mem_cnt == 3) hit = 1;
            if (ifid_valid) seen = 1;
        end
        n_chk++; if (!hit) begin n_fail++; $display("FAIL rm_setup: no outstanding request found, want one"); end
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            n_chk++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 32'h0 || if_busy !== 1'b0) begin n_fail++; $display("FAIL rm_reset[%0d]: valid=%b instr=%h pc=%h busy=%b want 0/%h/0/0", k, ifid_valid, ifid_instr, ifid_pc, if_busy, NOP); end
            #1;
            n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL rm_req[%0d]: got %b want 0", k, imem.req); end
        end
        rst = 1'b0; exp_pc = 32'h0;
        #1;
        n_chk++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin n_fail++; $display("FAIL rm_restart: req=%b addr=%h want 1/0", imem.req, imem.addr); end
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (ifid_valid) begin
                n_chk++; if (ifid_pc !== exp_pc || ifid_instr !== memword(exp_pc)) begin n_fail++; $display("FAIL rm_post: pc=%h instr=%h want %h/%h", ifid_pc, ifid_instr, exp_pc, memword(exp_pc)); end
                exp_pc += 32'd4; got++;
            end
        end
        n_chk++; if (got < 2) begin n_fail++; $display("FAIL rm_count: got %0d want >=2", got); end
    endtask

    task automatic test_random();
        int got = 0;
        logic l_st = 0, l_fl = 0, l_sel = 0, p_v = 0;
        logic [31:0] p_pc = 0, p_in = 0;
        do_reset(1, 60);
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (l_sel || l_fl) begin
                n_chk++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_fail++; $display("FAIL rnd_bubble: valid=%b instr=%h want 0/%h", ifid_valid, ifid_instr, NOP); end
            end else if (l_st) begin
                n_chk++; if (ifid_valid !== p_v || ifid_pc !== p_pc || ifid_instr !== p_in) begin n_fail++; $display("FAIL rnd_hold: %b/%h/%h want %b/%h/%h", ifid_valid, ifid_pc, ifid_instr, p_v, p_pc, p_in); end
            end else if (ifid_valid) begin
                n_chk++; if (ifid_pc !== exp_pc || ifid_instr !== memword(exp_pc)) begin n_fail++; $display("FAIL rnd_seq: pc=%h instr=%h want %h/%h", ifid_pc, ifid_instr, exp_pc, memword(exp_pc)); end
                exp_pc += 32'd4; got++;
            end
            n_chk++; if (if_busy !== mem_busy) begin n_fail++; $display("FAIL rnd_busy: got %b want %b", if_busy, mem_busy); end
            p_v = ifid_valid; p_pc = ifid_pc; p_in = ifid_instr;
            stall  = ($urandom_range(99) < 20);
            flush  = ($urandom_range(99) < 5);
            pc_sel = ($urandom_range(99) < 5);
            lat    = $urandom_range(3);
            if (pc_sel) begin
                bj = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : ($urandom() & 32'h0000_0FFF);
                exp_pc = bj & 32'hFFFF_FFFC; exp_fetch = exp_pc;
            end
            l_st = stall; l_fl = flush; l_sel = pc_sel;
            #1;
            if (mem_busy && !imem.rvalid) begin
                n_chk++; if (imem.req !== 1'b0) begin n_fail++; $display("FAIL rnd_req_wait: got %b want 0", imem.req); end
            end
            if (imem.req && imem.gnt) begin
                n_chk++; if (imem.addr !== exp_fetch) begin n_fail++; $display("FAIL rnd_addr: got %h want %h", imem.addr, exp_fetch); end
                exp_fetch += 32'd4;
            end
        end
        stall = 1'b0; flush = 1'b0; pc_sel = 1'b0;
        n_chk++; if (proto_err != 0) begin n_fail++; $display("FAIL rnd_outstanding: %0d overlapping grants, want 0", proto_err); end
        n_chk++; if (got < 30) begin n_fail++; $display("FAIL rnd_count: got %0d want >=30", got); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_redirect();
        test_flush();
        test_reset_midway();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
